// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: FSM state encodings,
// ALU opcodes and the bit positions of the {Z,V,N} status word.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_B = 3'd2,
        EXEC = 3'd3,
        WB   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_NOT = 2'b11
    } alu_op_t;

    localparam int STAT_Z = 2;
    localparam int STAT_V = 1;
    localparam int STAT_N = 0;

endpackage

// File: rtl/alu_sequencer_load_reg.sv
// Generic register with load enable and asynchronous active-low reset.
// Used for the A, B, C operand/result registers and the status register.
module load_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Hold value unless load is asserted; reset clears to zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle controller running one ALU operation per command:
// read operands from the register file, execute, latch result/status,
// and write back (unless compare-only).
//
// Handshake: start is a command-valid strobe sampled only in IDLE; busy
// is the inverse of ready (high in every non-IDLE state), so a start seen
// while busy is dropped, never queued. done pulses for exactly one cycle
// in the final state of each command.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             cmp,
    input  logic             use_imm,
    input  logic [WIDTH-1:0] imm,
    input  logic [AW-1:0]    rn,
    input  logic [AW-1:0]    rm,
    input  logic [AW-1:0]    rd,
    output logic [AW-1:0]    rf_readnum,
    input  logic [WIDTH-1:0] rf_rdata,
    output logic [AW-1:0]    rf_writenum,
    output logic             rf_write,
    output logic [WIDTH-1:0] rf_wdata,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] alu_out,
    input  logic [2:0]       alu_z,
    output logic [2:0]       status,
    output logic             busy,
    output logic             done,
    output logic [2:0]       state_dbg
);

    state_t state_q, state_d;

    logic [1:0]    op_q;
    logic          cmp_q;
    logic          use_imm_q;
    logic [AW-1:0] rn_q, rm_q, rd_q;

    logic             a_load, b_load, c_load, s_load;
    logic [WIDTH-1:0] b_d;
    logic [WIDTH-1:0] a_q, b_q, c_q;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the command fields when a start is accepted in IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q      <= '0;
            cmp_q     <= 1'b0;
            use_imm_q <= 1'b0;
            rn_q      <= '0;
            rm_q      <= '0;
            rd_q      <= '0;
        end else if (state_q == IDLE && start) begin
            op_q      <= op;
            cmp_q     <= cmp;
            use_imm_q <= use_imm;
            rn_q      <= rn;
            rm_q      <= rm;
            rd_q      <= rd;
        end
    end

    // Next-state logic and per-state control decode.
    always_comb begin
        state_d    = state_q;
        rf_readnum = '0;
        rf_write   = 1'b0;
        done       = 1'b0;
        a_load     = 1'b0;
        b_load     = 1'b0;
        b_d        = rf_rdata;
        c_load     = 1'b0;
        s_load     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    // The immediate goes straight into B so no read cycle is spent on it.
                    if (use_imm) begin
                        b_load = 1'b1;
                        b_d    = imm;
                    end
                    // NOT only consumes B, so the A read is skipped.
                    if (op != OP_NOT)  state_d = RD_A;
                    else if (!use_imm) state_d = RD_B;
                    else               state_d = EXEC;
                end
            end
            RD_A: begin
                rf_readnum = rn_q;
                a_load     = 1'b1;
                state_d    = use_imm_q ? EXEC : RD_B;
            end
            RD_B: begin
                rf_readnum = rm_q;
                b_load     = 1'b1;
                state_d    = EXEC;
            end
            EXEC: begin
                c_load = 1'b1;
                s_load = 1'b1;
                if (cmp_q) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = WB;
                end
            end
            WB: begin
                rf_write = 1'b1;
                done     = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    load_reg #(.WIDTH(WIDTH)) u_a_reg (
        .clk(clk), .reset(reset), .load(a_load), .d(rf_rdata), .q(a_q)
    );

    load_reg #(.WIDTH(WIDTH)) u_b_reg (
        .clk(clk), .reset(reset), .load(b_load), .d(b_d), .q(b_q)
    );

    load_reg #(.WIDTH(WIDTH)) u_c_reg (
        .clk(clk), .reset(reset), .load(c_load), .d(alu_out), .q(c_q)
    );

    load_reg #(.WIDTH(3)) u_status_reg (
        .clk(clk), .reset(reset), .load(s_load), .d(alu_z), .q(status)
    );

    // Datapath-facing outputs are straight register taps.
    always_comb begin
        busy        = (state_q != IDLE);
        rf_writenum = rd_q;
        rf_wdata    = c_q;
        alu_a       = a_q;
        alu_b       = b_q;
        alu_op      = op_q;
        state_dbg   = state_q;
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: 8x16 register file and ALU models around the DUT,
// directed commands with hand-computed results, scoreboard queue + monitor.
module tb_alu_sequencer;

    localparam int W  = 16;
    localparam int AW = 3;
    // Scoreboard entry: {wr_exp[25], wdata[24:9], rd[8:6], status[5:3], latency[2:0]}
    localparam int EW = 26;

    logic          clk, reset, start, cmp, use_imm;
    logic [1:0]    op;
    logic [W-1:0]  imm;
    logic [AW-1:0] rn, rm, rd;
    logic [AW-1:0] rf_readnum, rf_writenum;
    logic [W-1:0]  rf_rdata, rf_wdata, alu_a, alu_b, alu_out;
    logic          rf_write, busy, done;
    logic [1:0]    alu_op;
    logic [2:0]    alu_z, status, state_dbg;

    alu_sequencer #(.WIDTH(W), .AW(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .cmp(cmp),
        .use_imm(use_imm), .imm(imm), .rn(rn), .rm(rm), .rd(rd),
        .rf_readnum(rf_readnum), .rf_rdata(rf_rdata),
        .rf_writenum(rf_writenum), .rf_write(rf_write), .rf_wdata(rf_wdata),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_out(alu_out), .alu_z(alu_z),
        .status(status), .busy(busy), .done(done), .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- register file model ----------------
    logic [W-1:0]  rf [8];
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [W-1:0]  pre_data;

    assign rf_rdata = rf[rf_readnum];

    always @(posedge clk) begin
        if (pre_we)        rf[pre_addr]    <= pre_data;
        else if (rf_write) rf[rf_writenum] <= rf_wdata;
    end

    // ---------------- ALU model ----------------
    logic [W-1:0] res;
    logic         ovf;
    always_comb begin
        res = '0;
        ovf = 1'b0;
        case (alu_op)
            2'b00: begin
                res = alu_a + alu_b;
                ovf = (alu_a[W-1] == alu_b[W-1]) && (res[W-1] != alu_a[W-1]);
            end
            2'b01: begin
                res = alu_a - alu_b;
                ovf = (alu_a[W-1] != alu_b[W-1]) && (res[W-1] != alu_a[W-1]);
            end
            2'b10: res = alu_a & alu_b;
            default: res = ~alu_b;
        endcase
        alu_out = res;
        alu_z   = {(res == '0), ovf, res[W-1]};
    end

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int n_vec  = 0;
    int n_miss = 0;
    int done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    logic         prev_busy = 1'b0;
    int           lat = 0;
    int           wr  = 0;
    logic         stat_pend = 1'b0;
    logic [2:0]   stat_exp  = '0;
    logic [EW-1:0] e;

    always @(negedge clk) begin
        // Status is registered at the end of EXEC, so it is checked one cycle after done.
        if (stat_pend) begin
            check("status", {29'd0, status}, {29'd0, stat_exp});
            stat_pend = 1'b0;
        end
        if (busy) begin
            if (!prev_busy) begin
                lat = 1;
                wr  = int'(rf_write);
            end else begin
                lat = lat + 1;
                wr  = wr + int'(rf_write);
            end
        end
        prev_busy = busy;
        if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_done: got done=1 expected no command pending at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("latency", lat, {29'd0, e[2:0]});
                check("write_count", wr, {31'd0, e[25]});
                if (e[25]) begin
                    check("wdata", {16'd0, rf_wdata}, {16'd0, e[24:9]});
                    check("writenum", {29'd0, rf_writenum}, {29'd0, e[8:6]});
                end
                stat_exp  = e[5:3];
                stat_pend = 1'b1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic preload(input logic [AW-1:0] a, input logic [W-1:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || stat_pend || busy) && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (k >= 40) begin
            n_vec++;
            n_miss++;
            $display("FAIL timeout_%s: got busy=%0b pending=%0d expected idle within 40 cycles",
                     name, busy, exp_q.size());
        end
    endtask

    task automatic drive_fields(input logic [1:0] o, input logic c, input logic ui,
                                input logic [W-1:0] im, input logic [AW-1:0] a,
                                input logic [AW-1:0] b, input logic [AW-1:0] d);
        op = o; cmp = c; use_imm = ui; imm = im; rn = a; rm = b; rd = d;
    endtask

    // Issue one command and queue its expected response.
    task automatic run(input string name, input logic [1:0] o, input logic c, input logic ui,
                       input logic [W-1:0] im, input logic [AW-1:0] a, input logic [AW-1:0] b,
                       input logic [AW-1:0] d, input logic [W-1:0] wdata_exp,
                       input logic [2:0] st_exp, input logic [2:0] lat_exp);
        @(negedge clk);
        drive_fields(o, c, ui, im, a, b, d);
        exp_q.push_back({~c, wdata_exp, d, st_exp, lat_exp});
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle(name);
    endtask

    // ---------------- main stimulus ----------------
    int base;
    int k;
    logic saw_read;

    initial begin
        reset = 1'b0; start = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        drive_fields(2'b00, 1'b0, 1'b0, '0, '0, '0, '0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pre_we = 1'b1; pre_addr = AW'(i); pre_data = '0;
        end
        @(negedge clk);
        pre_we = 1'b0;

        // Reset state
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_rf_write", {31'd0, rf_write}, 32'd0);
        check("rst_status", {29'd0, status}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // 1: ADD reg/reg
        preload(3'd1, 16'h0005);
        preload(3'd2, 16'h0003);
        run("add", 2'b00, 1'b0, 1'b0, '0, 3'd1, 3'd2, 3'd3, 16'h0008, 3'b000, 3'd4);
        check("add_r3", {16'd0, rf[3]}, 32'h0008);

        // 2: SUB negative result, SUB zero result
        run("sub_neg", 2'b01, 1'b0, 1'b0, '0, 3'd2, 3'd1, 3'd3, 16'hFFFE, 3'b001, 3'd4);
        check("sub_neg_r3", {16'd0, rf[3]}, 32'hFFFE);
        run("sub_zero", 2'b01, 1'b0, 1'b0, '0, 3'd1, 3'd1, 3'd3, 16'h0000, 3'b100, 3'd4);
        check("sub_zero_r3", {16'd0, rf[3]}, 32'h0000);

        // 3: compare-only SUB with signed overflow, no writeback
        preload(3'd4, 16'h7FFF);
        preload(3'd5, 16'hFFFF);
        run("cmp", 2'b01, 1'b1, 1'b0, '0, 3'd4, 3'd5, 3'd0, 16'h8000, 3'b011, 3'd3);
        check("cmp_r0_kept", {16'd0, rf[0]}, 32'h0000);

        // 4: NOT immediate, no register reads
        saw_read = 1'b0;
        @(negedge clk);
        drive_fields(2'b11, 1'b0, 1'b1, 16'h00FF, 3'd0, 3'd0, 3'd6);
        exp_q.push_back({1'b1, 16'hFF00, 3'd6, 3'b001, 3'd2});
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (k = 0; k < 4; k++) begin
            @(negedge clk);
            if (state_dbg == 3'd1 || state_dbg == 3'd2) saw_read = 1'b1;
        end
        wait_idle("not_imm");
        check("not_imm_no_read", {31'd0, saw_read}, 32'd0);
        check("not_imm_r6", {16'd0, rf[6]}, 32'hFF00);

        // ADD immediate with overflow, AND reg/reg, NOT reg with rd == rm
        run("add_imm", 2'b00, 1'b0, 1'b1, 16'h7FFB, 3'd1, 3'd0, 3'd0, 16'h8000, 3'b011, 3'd3);
        check("add_imm_r0", {16'd0, rf[0]}, 32'h8000);
        run("and", 2'b10, 1'b0, 1'b0, '0, 3'd4, 3'd5, 3'd0, 16'h7FFF, 3'b000, 3'd4);
        check("and_r0", {16'd0, rf[0]}, 32'h7FFF);
        run("not_reg", 2'b11, 1'b0, 1'b0, '0, 3'd0, 3'd4, 3'd4, 16'h8000, 3'b001, 3'd3);
        check("not_reg_r4", {16'd0, rf[4]}, 32'h8000);

        // 5: start held high across a command, re-accepted right after done
        base = done_cnt;
        @(negedge clk);
        drive_fields(2'b00, 1'b0, 1'b0, '0, 3'd1, 3'd2, 3'd7);
        exp_q.push_back({1'b1, 16'h0008, 3'd7, 3'b000, 3'd4});
        exp_q.push_back({1'b1, 16'h0008, 3'd7, 3'b000, 3'd4});
        start = 1'b1;
        k = 0;
        while (done_cnt == base && k < 20) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle("held_start");
        repeat (6) @(negedge clk);
        check("held_start_cmds", done_cnt - base, 32'd2);
        check("held_start_r7", {16'd0, rf[7]}, 32'h0008);

        // 6: reset during EXEC aborts the command
        @(negedge clk);
        drive_fields(2'b00, 1'b0, 1'b0, '0, 3'd1, 3'd2, 3'd6);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        k = 0;
        while (state_dbg != 3'd3 && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("reached_exec", {29'd0, state_dbg}, 32'd3);
        #1 reset = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_status", {29'd0, status}, 32'd0);
        check("abort_rf_write", {31'd0, rf_write}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_r6_kept", {16'd0, rf[6]}, 32'hFF00);

        // Recovery: next command completes normally
        run("after_reset", 2'b01, 1'b0, 1'b0, '0, 3'd1, 3'd2, 3'd6, 16'h0002, 3'b000, 3'd4);
        check("after_reset_r6", {16'd0, rf[6]}, 32'h0002);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
